// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Time-shares one single-cycle ALU between two requesters. At most one
// operation is accepted per cycle, chosen round-robin when both requesters
// are valid. The ALU result and zero flag are captured into a single
// response register. That register is returned to the requester that issued
// the operation over a valid/ready handshake. Saturating per-requester grant
// counters are kept for performance monitoring.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake for requester N
//   reqN_a, reqN_b, reqN_op    operands and 3-bit ALU op for requester N
//   alu_a, alu_b, alu_op       operands/op driven to the shared ALU
//   alu_r, alu_zero            result and zero flag returned by the ALU
//   rspN_valid/ready           response handshake for requester N
//   rsp_r, rsp_zero            buffered result, shared by both response ports
//   gnt_cnt0, gnt_cnt1         saturating accepted-operation counters
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic rsp_valid;
  logic rsp_owner;
  logic last_gnt;
  logic cand_valid;
  logic cand_sel;
  logic owner_ready;
  logic slot_free;
  logic grant;

  assign rsp0_valid = rsp_valid && !rsp_owner;
  assign rsp1_valid = rsp_valid &&  rsp_owner;

  // The single slot is reusable when empty or when its owner drains it this
  // cycle, so a drain and a new accept can happen together.
  assign owner_ready = rsp_owner ? rsp1_ready : rsp0_ready;
  assign slot_free   = !rsp_valid || owner_ready;

  // Round-robin: on a tie the requester that did not win last time is chosen.
  always_comb begin
    cand_valid = req0_valid || req1_valid;
    cand_sel   = 1'b0;
    if (req0_valid && req1_valid)
      cand_sel = ~last_gnt;
    else if (req1_valid)
      cand_sel = 1'b1;
  end

  assign grant      = cand_valid && slot_free;
  assign req0_ready = grant && !cand_sel;
  assign req1_ready = grant &&  cand_sel;

  // The candidate's operands go to the ALU even while stalled, so the ALU
  // path is independent of the response handshake; idle drives zeros.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 3'b000;
    if (cand_valid) begin
      if (cand_sel) begin
        alu_a  = req1_a;
        alu_b  = req1_b;
        alu_op = req1_op;
      end else begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
      end
    end
  end

  // Response register: loads on grant, empties on a drain without a grant,
  // and otherwise holds so data stays stable under back-pressure.
  // last_gnt resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_r     <= '0;
      rsp_zero  <= 1'b0;
      last_gnt  <= 1'b1;
    end else if (grant) begin
      rsp_valid <= 1'b1;
      rsp_owner <= cand_sel;
      rsp_r     <= alu_r;
      rsp_zero  <= alu_zero;
      last_gnt  <= cand_sel;
    end else if (rsp_valid && owner_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Grant counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_ready && gnt_cnt0 != CNT_MAX)
        gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (req1_ready && gnt_cnt1 != CNT_MAX)
        gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter and result buffer that time-shares the single-cycle 32-bit ALU (3-bit op encoding) between two independent requesters, such as the main datapath and an address/branch helper unit. It grants at most one operation per cycle using round-robin priority. It drives the shared ALU's operand and op inputs, and captures the ALU result and zero flag into a one-entry response register. The response is returned to the owning requester over a valid/ready handshake, and per-requester saturating grant counters are kept for performance monitoring.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- CNT_W, 16, width of each grant counter.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester N presents an operation.
- req0_ready / req1_ready  out  1  operation accepted this cycle (combinational).
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_op / req1_op  in  3  ALU op: 000 and, 001 or, 010 add, 011 xor, 100 sub, 101 shift right, 110 shift left, 111 nor.
- alu_a, alu_b  out  WIDTH  operands to shared ALU.
- alu_op  out  3  op to shared ALU.
- alu_r  in  WIDTH  ALU result (combinational from alu_a/b/op).
- alu_zero  in  1  ALU zero flag.
- rsp0_valid / rsp1_valid  out  1  response for requester N is held.
- rsp0_ready / rsp1_ready  in  1  requester N consumes its response.
- rsp_r  out  WIDTH  buffered result (shared by both response ports; qualified by rspN_valid).
- rsp_zero  out  1  buffered zero flag.
- gnt_cnt0 / gnt_cnt1  out  CNT_W  saturating count of accepted operations per requester.

## Operation
- State: rsp_valid, rsp_owner (0/1), rsp_r, rsp_zero, last_gnt (0/1), gnt_cnt0, gnt_cnt1.
- rspN_valid = rsp_valid && rsp_owner==N.
- slot_free = !rsp_valid || rsp(owner)_ready. A drain and a new accept in the same cycle are legal.
- Candidate selection:
  - only req0_valid -> 0; only req1_valid -> 1.
  - both valid -> the requester != last_gnt.
  - neither valid -> none.
- alu_a/alu_b/alu_op = candidate's operands. If there is no candidate, drive all zeros (op 000).
- Grant = candidate exists && slot_free. reqN_ready = 1 only for the granted requester; never both.
- On grant, at the edge:
  - rsp_r <= alu_r, rsp_zero <= alu_zero.
  - rsp_owner <= granted, rsp_valid <= 1, last_gnt <= granted.
  - gnt_cntN increments, saturating at 2^CNT_W-1.
- No grant but slot drained -> rsp_valid <= 0. No grant and slot not drained -> all state holds.
- rsp_r/rsp_zero stay stable while rsp_valid && !ready.
- The arbiter never inspects the op; all 8 codes are passed through unchanged.
- Reset values: rsp_valid 0, rsp_owner 0, rsp_r 0, rsp_zero 0, last_gnt 1 (so requester 0 wins the first tie), counters 0.
- Reset asserted mid-operation: the held response is discarded immediately (rspN_valid drop asynchronously). The pending request is not accepted; the requester must re-present it after reset.

## Timing
- Latency: request accepted at edge k -> rspN_valid high in cycle k+1.
- Throughput: one op/cycle total when the owner's rsp ready is held high.
- Combinational paths:
  - req*_valid -> alu_* -> (external ALU) -> captured at the edge.
  - rspN_ready -> reqN_ready, via slot_free.
- No path from alu_r to any output except through the register.
- Fairness: with both requesters continuously valid and ready, grants strictly alternate 0,1,0,1...
- Back-pressure: owner ready low -> no grant to either requester. The non-owner is stalled too (single shared slot).

## Test plan
- Reset: with rst_n low, all outputs are 0 and gnt_cnt* = 0. Release, then req0 add a=5, b=7 -> req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp_r=12, rsp_zero=0, rsp1_valid=0, gnt_cnt0=1.
- Tie: both valid every cycle (req0 sub 9-9, req1 or 0xF0|0x0F), both rsp ready=1 -> grants 0,1,0,1. Responses alternate rsp_r=0/zero=1 and rsp_r=0xFF/zero=0.
- Back-pressure: rsp0_ready=0 for 3 cycles after a req0 grant -> rsp_r held constant, req0_ready=req1_ready=0. Raise rsp0_ready with req1 valid -> drain and grant to req1 in the same cycle; next cycle rsp1_valid=1.
- Idle: no requests -> alu_a=alu_b=0, alu_op=000. A held response stays until consumed, then rsp_valid=0.
- Reset mid-operation: assert rst_n low while rsp1_valid=1 -> rsp1_valid=0 immediately, last_gnt=1. After release, a tie grants requester 0 first.
- Saturation: force 2^16+3 grants to req1 -> gnt_cnt1=0xFFFF and remains there; gnt_cnt0 unaffected.
